// File: rtl/soc_pkg.sv
// Shared types and constants for the run monitor: verdict states, default
// bus addresses and LED pattern helpers.
package soc_pkg;

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} mon_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_1004;

  // Alternating pattern anchored so the MSB is always 1, for any width.
  function automatic logic [63:0] led_alt(input int w);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < w; i++) p[i] = (((w - 1 - i) % 2) == 0);
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop, w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/soc_run_monitor.sv
// Run-control monitor on the CPU data bus: cycle count, TOHOST verdict,
// cycle-limit timeout, console byte FIFO and LED status.
module soc_run_monitor
  import soc_pkg::*;
#(
  parameter int                  ADDR_W       = 32,
  parameter int                  DATA_W       = 32,
  parameter int                  CYCLE_W      = 32,
  parameter logic [CYCLE_W-1:0]  MAX_CYCLES   = CYCLE_W'(200),
  parameter logic [ADDR_W-1:0]   TOHOST_ADDR  = ADDR_W'(TOHOST_ADDR_DEF),
  parameter logic [ADDR_W-1:0]   CONSOLE_ADDR = ADDR_W'(CONSOLE_ADDR_DEF),
  parameter int                  CON_DEPTH    = 16,
  parameter int                  LED_W        = 4,
  parameter int                  HB_BIT       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                done,
  output logic                pass,
  output logic [DATA_W-2:0]   fail_code,
  output logic [CYCLE_W-1:0]  cycles,
  output logic [LED_W-1:0]    led,
  output logic                con_valid,
  output logic [7:0]          con_data,
  input  logic                con_ready,
  output logic                con_overflow
);
  localparam logic [CYCLE_W-1:0] LIMIT   = MAX_CYCLES - 1'b1;
  localparam logic [LED_W-1:0]   LED_ALT = LED_W'(led_alt(LED_W));

  mon_state_e          r_state, w_state_nxt;
  logic [CYCLE_W-1:0]  r_cycles;
  logic [DATA_W-2:0]   r_fail_code;
  logic                r_overflow;
  logic                w_tohost, w_con_push, w_limit, w_full, w_empty, w_unused;

  assign w_unused   = ^mem_addr[1:0];
  // Only odd TOHOST values are verdicts; even values are ignored entirely.
  assign w_tohost   = (|mem_wstrb) && mem_wdata[0]
                      && (mem_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);
  assign w_con_push = mem_wstrb[0] && (mem_addr[ADDR_W-1:2] == CONSOLE_ADDR[ADDR_W-1:2]);
  assign w_limit    = enable && (r_cycles == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if (w_tohost)     w_state_nxt = (mem_wdata == DATA_W'(1)) ? PASS : FAIL;
      else if (w_limit) w_state_nxt = TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles    <= '0;
      r_fail_code <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == RUN && enable) r_cycles <= r_cycles + 1'b1;
      if (r_state == RUN && w_tohost && mem_wdata != DATA_W'(1))
        r_fail_code <= mem_wdata[DATA_W-1:1];
      if (w_con_push && w_full && !(con_valid && con_ready)) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    led = '0;
    case (r_state)
      RUN:     led[0] = r_cycles[HB_BIT];
      PASS:    led = '1;
      FAIL:    led = {1'b1, r_fail_code[LED_W-2:0]};
      TIMEOUT: led = LED_ALT;
      default: led = '0;
    endcase
  end

  sync_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_con_push),
    .i_pop   (con_ready),
    .i_data  (mem_wdata[7:0]),
    .o_data  (con_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign con_valid    = !w_empty;
  assign con_overflow = r_overflow;
  assign done         = (r_state != RUN);
  assign pass         = (r_state == PASS);
  assign fail_code    = r_fail_code;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Directed scenarios plus randomized bus traffic, each cycle compared against
// a queue-based behavioural model of the monitor.
module tb_soc_run_monitor;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE = 32'h0000_1004;
  localparam int          MAXC    = 200;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset, enable, con_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done, pass, con_valid, con_overflow;
  logic [30:0] fail_code;
  logic [31:0] cycles;
  logic [3:0]  led;
  logic [7:0]  con_data;

  soc_run_monitor #(.MAX_CYCLES(32'(MAXC)), .CON_DEPTH(DEPTH), .LED_W(4), .HB_BIT(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .done(done), .pass(pass), .fail_code(fail_code), .cycles(cycles),
    .led(led), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .con_overflow(con_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: 0 running, 1 passed, 2 failed, 3 timed out.
  int          m_st;
  int unsigned m_cyc;
  logic [30:0] m_fc;
  bit          m_ovf;
  logic [7:0]  m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_led();
    case (m_st)
      0: return {3'b000, 1'((m_cyc >> 3) & 1)};
      1: return 4'b1111;
      2: return {1'b1, m_fc[2:0]};
      default: return 4'b1010;
    endcase
  endfunction

  task automatic check_all();
    chk("done", 64'(done), 64'(m_st != 0));
    chk("pass", 64'(pass), 64'(m_st == 1));
    chk("cycles", 64'(cycles), 64'(m_cyc));
    chk("fail_code", 64'(fail_code), 64'(m_fc));
    chk("led", 64'(led), 64'(exp_led()));
    chk("con_valid", 64'(con_valid), 64'(m_q.size() > 0));
    chk("con_overflow", 64'(con_overflow), 64'(m_ovf));
    if (m_q.size() > 0) chk("con_data", 64'(con_data), 64'(m_q[0]));
  endtask

  task automatic tick();
    bit tohost, conp, pop, full, lim;
    tohost = (mem_wstrb != 0) && mem_wdata[0] && ((mem_addr >> 2) == (TOHOST >> 2));
    conp   = mem_wstrb[0] && ((mem_addr >> 2) == (CONSOLE >> 2));
    pop    = (m_q.size() > 0) && con_ready;
    full   = (m_q.size() == DEPTH);
    lim    = enable && (m_cyc == MAXC - 1);
    @(posedge clk);
    #1;
    if (reset) begin
      m_st = 0; m_cyc = 0; m_fc = '0; m_ovf = 0; m_q.delete();
    end else begin
      if (m_st == 0) begin
        if (enable) m_cyc++;
        if (tohost) begin
          if (mem_wdata == 1) m_st = 1;
          else begin m_st = 2; m_fc = mem_wdata[31:1]; end
        end else if (lim) m_st = 3;
      end
      if (pop) void'(m_q.pop_front());
      if (conp) begin
        if (!full || pop) m_q.push_back(mem_wdata[7:0]);
        else m_ovf = 1;
      end
    end
    check_all();
  endtask

  task automatic idle();
    mem_addr = 32'h0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wstrb = 4'b0001; mem_wdata = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    string s;
    reset = 1'b1; enable = 1'b1; con_ready = 1'b0; idle();
    m_st = 0; m_cyc = 0; m_fc = '0; m_ovf = 0;
    tick(); reset = 1'b0;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);

    // T1 pass at cycle 50, later store ignored
    repeat (50) tick();
    store(TOHOST, 32'd1);
    chk("T1_done", 64'(done), 64'd1);
    chk("T1_pass", 64'(pass), 64'd1);
    chk("T1_led", 64'(led), 64'hF);
    chk("T1_cycles", 64'(cycles), 64'd51);
    store(TOHOST, 32'd3);
    chk("T1_sticky_pass", 64'(pass), 64'd1);
    chk("T1_frozen", 64'(cycles), 64'd51);

    // T2 fail code
    do_reset();
    repeat (10) tick();
    store(TOHOST, 32'h0B);
    chk("T2_fc", 64'(fail_code), 64'd5);
    chk("T2_led", 64'(led), 64'hD);
    chk("T2_pass", 64'(pass), 64'd0);
    chk("T2_done", 64'(done), 64'd1);

    // T3 timeout
    do_reset();
    repeat (MAXC - 1) tick();
    chk("T3_not_yet", 64'(done), 64'd0);
    tick();
    chk("T3_done", 64'(done), 64'd1);
    chk("T3_cycles", 64'(cycles), 64'd200);
    chk("T3_led", 64'(led), 64'hA);

    // T3b store on the limit cycle wins
    do_reset();
    repeat (MAXC - 1) tick();
    store(TOHOST, 32'd1);
    chk("T3b_pass", 64'(pass), 64'd1);
    chk("T3b_cycles", 64'(cycles), 64'd200);

    // T4 pause delays timeout by 30
    do_reset();
    repeat (50) tick();
    enable = 1'b0; repeat (30) tick(); enable = 1'b1;
    repeat (MAXC - 51) tick();
    chk("T4_not_yet", 64'(done), 64'd0);
    chk("T4_cyc", 64'(cycles), 64'd199);
    tick();
    chk("T4_done", 64'(led), 64'hA);

    // T5 HELLO into depth-4 FIFO
    do_reset();
    enable = 1'b0; s = "HELLO";
    for (int i = 0; i < 5; i++) store(CONSOLE, {24'h0, s[i]});
    chk("T5_ovf", 64'(con_overflow), 64'd1);
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("T5_data", 64'(con_data), 64'(s[i]));
      tick();
    end
    con_ready = 1'b0;
    chk("T5_empty", 64'(con_valid), 64'd0);

    // T5b full FIFO with simultaneous push and pop
    do_reset();
    s = "ABCDE";
    for (int i = 0; i < 4; i++) store(CONSOLE, {24'h0, s[i]});
    con_ready = 1'b1;
    store(CONSOLE + 32'd2, {24'h0, s[4]});
    for (int i = 1; i < 5; i++) begin
      chk("T5b_data", 64'(con_data), 64'(s[i]));
      tick();
    end
    con_ready = 1'b0;
    chk("T5b_empty", 64'(con_valid), 64'd0);
    chk("T5b_ovf", 64'(con_overflow), 64'd0);

    // T6 reset after pass with bytes queued
    do_reset();
    enable = 1'b1;
    store(TOHOST, 32'd1);
    store(CONSOLE, 32'h78);
    store(CONSOLE, 32'h79);
    chk("T6_pre_valid", 64'(con_valid), 64'd1);
    do_reset();
    chk("T6_done", 64'(done), 64'd0);
    chk("T6_cycles", 64'(cycles), 64'd0);
    chk("T6_valid", 64'(con_valid), 64'd0);
    chk("T6_ovf", 64'(con_overflow), 64'd0);
    chk("T6_led", 64'(led), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      con_ready = ($urandom_range(0, 2) == 0);
      mem_wstrb = 4'($urandom_range(0, 15));
      mem_wdata = $urandom;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        mem_addr = TOHOST | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) mem_wdata = 32'd1;
      end else if (r < 40) mem_addr = CONSOLE | 32'($urandom_range(0, 3));
      else mem_addr = $urandom;
      tick();
    end
    reset = 1'b0; idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
